// File: rtl/seq_detector_param_pkg.sv
// Shared types for the programmable symbol-sequence detector.
// Mode encoding is kept here so the top and the bench agree on it.
package seq_detector_param_pkg;

   typedef enum logic {
      STRICT = 1'b0,
      REPEAT = 1'b1
   } mode_e;

   function automatic int state_w(input int seq_len);
      return $clog2(seq_len + 1);
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with clear taking priority over increment.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && (cnt != {CNT_W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable symbol-sequence detector with repeat-hold mode,
// one-cycle match pulse and saturating match counter.
module seq_detector_param
   import seq_detector_param_pkg::*;
#(
   parameter int SYM_W = 2,
   parameter int SEQ_LEN = 3,
   parameter int CNT_W = 8,
   parameter logic [SEQ_LEN*SYM_W-1:0] DEFAULT_PAT = {2'd3, 2'd2, 2'd1}
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         sym_valid,
   input  logic [SYM_W-1:0]             sym,
   input  logic                         mode_repeat,
   input  logic                         pat_we,
   input  logic [$clog2(SEQ_LEN)-1:0]   pat_idx,
   input  logic [SYM_W-1:0]             pat_data,
   input  logic                         cnt_clr,
   output logic                         ans,
   output logic                         match_pulse,
   output logic [CNT_W-1:0]             match_cnt,
   output logic [$clog2(SEQ_LEN+1)-1:0] progress
);

   localparam int KW = state_w(SEQ_LEN);
   localparam int IW = $clog2(SEQ_LEN);
   localparam logic [KW-1:0] LK = KW'(SEQ_LEN);

   logic [SEQ_LEN*SYM_W-1:0] pat;
   logic [KW-1:0]            k;
   logic [KW-1:0]            k_nxt;
   logic [SYM_W-1:0]         cur;
   logic [SYM_W-1:0]         prv;
   logic                     wr_ok;
   logic                     pulse_nxt;

   assign wr_ok = pat_we && (int'(pat_idx) < SEQ_LEN);

   // P[k] and P[k-1] selected by constant-index muxes
   always_comb begin
      cur = '0;
      prv = '0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (KW'(i) == k)
            cur = pat[i*SYM_W +: SYM_W];
         if (KW'(i + 1) == k)
            prv = pat[i*SYM_W +: SYM_W];
      end
   end

   always_comb begin
      k_nxt = k;
      if (wr_ok)
         k_nxt = '0;
      else if (sym_valid) begin
         if ((k != LK) && (sym == cur))
            k_nxt = k + 1'b1;
         else if ((mode_e'(mode_repeat) == REPEAT) && (k != '0)
                  && (sym == prv))
            k_nxt = k;
         else if (sym == pat[SYM_W-1:0])
            k_nxt = KW'(1);
         else
            k_nxt = '0;
      end
   end

   assign pulse_nxt = (k_nxt == LK) && (k != LK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         k           <= '0;
         match_pulse <= 1'b0;
         pat         <= DEFAULT_PAT;
      end else begin
         k           <= k_nxt;
         match_pulse <= pulse_nxt;
         for (int i = 0; i < SEQ_LEN; i++)
            if (wr_ok && (IW'(i) == pat_idx))
               pat[i*SYM_W +: SYM_W] <= pat_data;
      end
   end

   assign ans      = (k == LK);
   assign progress = k;

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (pulse_nxt),
      .clr  (cnt_clr),
      .cnt  (match_cnt)
   );

endmodule
